// File: rtl/antares_fetch_unit_if.sv
// antares_fetch_unit_if: instruction-memory fetch bus between the fetch unit and imem.
//   imem_address  32  fetch address (word aligned), driven by master
//   imem_request   1  fetch request, held with stable address until imem_ready
//   imem_ready     1  one-cycle pulse from slave: imem_data valid, request complete
//   imem_data     32  fetched instruction, driven by slave
interface antares_fetch_unit_if;
    logic [31:0] imem_address;
    logic        imem_request;
    logic        imem_ready;
    logic [31:0] imem_data;
    modport master (output imem_address, imem_request, input imem_ready, imem_data);
    modport slave (input imem_address, imem_request, output imem_ready, imem_data);
endinterface

// File: rtl/antares_fetch_unit.sv
// antares_fetch_unit: instruction-fetch stage owning the PC, one outstanding imem request,
// one instruction per cycle to IF/ID, delay-slot aware branch redirect, exception redirect.
//   clk, rst            clock, synchronous active-high reset
//   imem                fetch bus (master side)
//   id_stall_i          ID stalled, IF/ID holds
//   id_is_branch_i      instruction in ID has a delay slot
//   id_branch_taken_i   branch/jump in ID is taken, target id_branch_target_i
//   exc_redirect_i      exception/ERET redirect to exc_vector_i, highest priority
//   if_instruction_o    instruction to IF/ID (0 when stalled)
//   if_pc_add4_o        presented PC + 4
//   if_exception_pc_o   presented PC
//   if_is_bds_o         presented instruction is a delay slot
//   if_stall_o          no valid instruction this cycle
module antares_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    antares_fetch_unit_if.master        imem,
    input  logic                        id_stall_i,
    input  logic                        id_is_branch_i,
    input  logic                        id_branch_taken_i,
    input  logic [31:0]                 id_branch_target_i,
    input  logic                        exc_redirect_i,
    input  logic [31:0]                 exc_vector_i,
    output logic [31:0]                 if_instruction_o,
    output logic [31:0]                 if_pc_add4_o,
    output logic [31:0]                 if_exception_pc_o,
    output logic                        if_is_bds_o,
    output logic                        if_stall_o
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, hold_q, hold_d, target_q, target_d, stale_q, stale_d;
    logic        branch_pending_q, branch_pending_d, bds_pending_q, bds_pending_d;
    logic        present, valid, consume;
    logic [31:0] next_pc;

    // In DISCARD the abandoned request keeps its original address until memory completes it.
    assign imem.imem_address = state_q == DISCARD ? stale_q : pc_q;
    assign imem.imem_request = !rst && state_q != HOLD;
    assign if_stall_o        = !valid;
    assign if_instruction_o  = !valid ? 32'd0 : state_q == HOLD ? hold_q : imem.imem_data;
    assign if_exception_pc_o = pc_q;
    assign if_pc_add4_o      = pc_q + 32'd4;
    assign if_is_bds_o       = !rst && (id_is_branch_i || bds_pending_q);

    always_comb begin
        present          = (state_q == FETCH && imem.imem_ready) || state_q == HOLD;
        valid            = !rst && present && !exc_redirect_i;
        consume          = valid && !id_stall_i;
        next_pc          = (id_branch_taken_i && !id_stall_i) ? id_branch_target_i :
                           branch_pending_q ? target_q : pc_q + 32'd4;
        state_d          = state_q;
        pc_d             = pc_q;
        hold_d           = hold_q;
        target_d         = target_q;
        stale_d          = stale_q;
        branch_pending_d = branch_pending_q;
        bds_pending_d    = bds_pending_q;
        if (exc_redirect_i) begin
            pc_d             = exc_vector_i;
            hold_d           = 32'd0;
            branch_pending_d = 1'b0;
            bds_pending_d    = 1'b0;
            stale_d          = state_q == FETCH ? pc_q : stale_q;
            state_d          = (state_q != HOLD && !imem.imem_ready) ? DISCARD : FETCH;
        end else if (consume) begin
            pc_d             = next_pc;
            state_d          = FETCH;
            branch_pending_d = 1'b0;
            bds_pending_d    = 1'b0;
        end else begin
            if (state_q == FETCH && imem.imem_ready) begin
                hold_d  = imem.imem_data;
                state_d = HOLD;
            end
            if (state_q == DISCARD && imem.imem_ready) state_d = FETCH;
            // Reaching here with id_stall_i low means IF had nothing to give: the branch
            // leaves ID before its delay slot, so remember it for when the slot arrives.
            if (id_branch_taken_i && !id_stall_i) begin
                branch_pending_d = 1'b1;
                target_d         = id_branch_target_i;
            end
            if (id_is_branch_i && !id_stall_i) bds_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= FETCH;
            pc_q             <= RESET_VECTOR;
            hold_q           <= 32'd0;
            target_q         <= 32'd0;
            stale_q          <= 32'd0;
            branch_pending_q <= 1'b0;
            bds_pending_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            hold_q           <= hold_d;
            target_q         <= target_d;
            stale_q          <= stale_d;
            branch_pending_q <= branch_pending_d;
            bds_pending_q    <= bds_pending_d;
        end
    end
endmodule

// File: tb/tb_antares_fetch_unit.sv
// tb_antares_fetch_unit: directed bench for antares_fetch_unit with an expected fetch-stream model.
module tb_antares_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_stall_i = 1'b0, id_is_branch_i = 1'b0, id_branch_taken_i = 1'b0, exc_redirect_i = 1'b0;
    logic [31:0] id_branch_target_i = 32'd0, exc_vector_i = 32'd0;
    logic [31:0] if_instruction_o, if_pc_add4_o, if_exception_pc_o;
    logic        if_is_bds_o, if_stall_o;

    typedef struct { logic [31:0] pc; logic bds; } exp_t;
    exp_t q[$];
    int   lat = 0;
    int   mem_cnt = 0;
    int   n_vec = 0, n_err = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    antares_fetch_unit_if imem_bus();

    antares_fetch_unit dut (
        .clk                (clk),
        .rst                (rst),
        .imem               (imem_bus),
        .id_stall_i         (id_stall_i),
        .id_is_branch_i     (id_is_branch_i),
        .id_branch_taken_i  (id_branch_taken_i),
        .id_branch_target_i (id_branch_target_i),
        .exc_redirect_i     (exc_redirect_i),
        .exc_vector_i       (exc_vector_i),
        .if_instruction_o   (if_instruction_o),
        .if_pc_add4_o       (if_pc_add4_o),
        .if_exception_pc_o  (if_exception_pc_o),
        .if_is_bds_o        (if_is_bds_o),
        .if_stall_o         (if_stall_o)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Program-order fetch stream from base; the slot after bpc is a delay slot, then tgt.
    task automatic model_stream(input logic [31:0] base, input logic br, input logic [31:0] bpc, input logic [31:0] tgt);
        logic [31:0] p;
        logic        slot;
        p = base;
        q.delete();
        for (int i = 0; i < 12; i++) begin
            slot = br && p == bpc + 32'd4;
            q.push_back('{p, slot});
            p = slot ? tgt : p + 32'd4;
        end
    endtask

    task automatic redirect(input logic [31:0] vec, input logic br, input logic [31:0] bpc, input logic [31:0] tgt);
        cycle();
        exc_redirect_i = 1'b1;
        exc_vector_i   = vec;
        model_stream(vec, br, bpc, tgt);
        cycle();
        exc_redirect_i = 1'b0;
    endtask

    task automatic wait_pc(input logic [31:0] a);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = !if_stall_o && if_exception_pc_o == a;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_pc: pc %h never presented, last pc %h", a, if_exception_pc_o);
        end
    endtask

    // Memory slave: answers a request after lat idle cycles of it being held.
    initial begin
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_data  = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_bus.imem_request && mem_cnt >= lat) begin
                imem_bus.imem_ready = 1'b1;
                imem_bus.imem_data  = mem(imem_bus.imem_address);
                mem_cnt = 0;
            end else begin
                imem_bus.imem_ready = 1'b0;
                imem_bus.imem_data  = 32'hDEAD_BEEF;
                mem_cnt = imem_bus.imem_request ? mem_cnt + 1 : 0;
            end
        end
    end

    // Compare process: every presented instruction must be the next one of the expected stream.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_stall", 32'(if_stall_o), 32'd1);
            chk("rst_req", 32'(imem_bus.imem_request), 32'd0);
            chk("rst_instr", if_instruction_o, 32'd0);
            chk("rst_bds", 32'(if_is_bds_o), 32'd0);
            prev_pend = 1'b0;
        end else begin
            if (prev_pend && imem_bus.imem_request) chk("addr_stable", imem_bus.imem_address, prev_addr);
            prev_pend = imem_bus.imem_request && !imem_bus.imem_ready;
            prev_addr = imem_bus.imem_address;
            if (exc_redirect_i) chk("exc_stall", 32'(if_stall_o), 32'd1);
            else if (!if_stall_o) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL q_empty: presented pc %h, none expected", if_exception_pc_o);
                end else begin
                    chk("m_pc", if_exception_pc_o, q[0].pc);
                    chk("m_instr", if_instruction_o, mem(q[0].pc));
                    chk("m_add4", if_pc_add4_o, q[0].pc + 32'd4);
                    chk("m_bds", 32'(if_is_bds_o), 32'(q[0].bds));
                    if (!id_stall_i) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) cycle();
        @(negedge clk);
        chk("rst_addr", imem_bus.imem_address, 32'hBFC0_0000);
        cycle();
        rst = 1'b0;
        model_stream(32'hBFC0_0000, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t1_addr0", imem_bus.imem_address, 32'hBFC0_0000);
        chk("t1_req0", 32'(imem_bus.imem_request), 32'd1);
        chk("t1_stall0", 32'(if_stall_o), 32'd0);
        cycle();
        @(negedge clk);
        chk("t1_addr1", imem_bus.imem_address, 32'hBFC0_0004);
        cycle();
        @(negedge clk);
        chk("t1_addr2", imem_bus.imem_address, 32'hBFC0_0008);
        cycle();
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cycle();
            @(negedge clk);
            chk("t2_stall", 32'(if_stall_o), 32'd1);
            chk("t2_req", 32'(imem_bus.imem_request), 32'd1);
            chk("t2_addr", imem_bus.imem_address, 32'hBFC0_000C);
        end
        cycle();
        @(negedge clk);
        chk("t2_ready_stall", 32'(if_stall_o), 32'd0);
        chk("t2_ready_pc", if_exception_pc_o, 32'hBFC0_000C);
        cycle();
        lat = 0;
        id_stall_i = 1'b1;
        @(negedge clk);
        chk("t3_pc", if_exception_pc_o, 32'hBFC0_0010);
        chk("t3_instr", if_instruction_o, 32'hE59A_0F1F);
        cycle();
        @(negedge clk);
        chk("t3_hold_req", 32'(imem_bus.imem_request), 32'd0);
        chk("t3_hold_instr", if_instruction_o, 32'hE59A_0F1F);
        cycle();
        id_stall_i = 1'b0;
        @(negedge clk);
        chk("t3_release_pc", if_exception_pc_o, 32'hBFC0_0010);
        chk("t3_release_stall", 32'(if_stall_o), 32'd0);
        cycle();
        @(negedge clk);
        chk("t3_next_pc", if_exception_pc_o, 32'hBFC0_0014);

        redirect(32'h0000_0100, 1'b1, 32'h0000_0100, 32'h0000_0200);
        wait_pc(32'h0000_0100);
        cycle();
        id_is_branch_i = 1'b1;
        id_branch_taken_i = 1'b1;
        id_branch_target_i = 32'h0000_0200;
        @(negedge clk);
        chk("t4_bds_pc", if_exception_pc_o, 32'h0000_0104);
        chk("t4_bds_flag", 32'(if_is_bds_o), 32'd1);
        cycle();
        id_is_branch_i = 1'b0;
        id_branch_taken_i = 1'b0;
        @(negedge clk);
        chk("t4_target_pc", if_exception_pc_o, 32'h0000_0200);
        chk("t4_target_bds", 32'(if_is_bds_o), 32'd0);

        redirect(32'h0000_0100, 1'b1, 32'h0000_0100, 32'h0000_0200);
        wait_pc(32'h0000_0100);
        cycle();
        id_is_branch_i = 1'b1;
        id_branch_taken_i = 1'b1;
        id_branch_target_i = 32'h0000_0200;
        lat = 2;
        @(negedge clk);
        chk("t5_wait_stall", 32'(if_stall_o), 32'd1);
        chk("t5_wait_bds", 32'(if_is_bds_o), 32'd1);
        cycle();
        id_is_branch_i = 1'b0;
        id_branch_taken_i = 1'b0;
        @(negedge clk);
        chk("t5_pend_stall", 32'(if_stall_o), 32'd1);
        chk("t5_pend_bds", 32'(if_is_bds_o), 32'd1);
        cycle();
        @(negedge clk);
        chk("t5_bds_pc", if_exception_pc_o, 32'h0000_0104);
        chk("t5_bds_flag", 32'(if_is_bds_o), 32'd1);
        cycle();
        lat = 0;
        @(negedge clk);
        chk("t5_target_pc", if_exception_pc_o, 32'h0000_0200);

        cycle();
        lat = 3;
        @(negedge clk);
        chk("t6_pre_addr", imem_bus.imem_address, 32'h0000_0204);
        redirect(32'h8000_0180, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t6_discard_addr", imem_bus.imem_address, 32'h0000_0204);
        chk("t6_discard_req", 32'(imem_bus.imem_request), 32'd1);
        chk("t6_discard_stall", 32'(if_stall_o), 32'd1);
        cycle();
        @(negedge clk);
        chk("t6_drop_stall", 32'(if_stall_o), 32'd1);
        cycle();
        lat = 0;
        @(negedge clk);
        chk("t6_new_addr", imem_bus.imem_address, 32'h8000_0180);
        chk("t6_new_stall", 32'(if_stall_o), 32'd0);
        chk("t6_new_instr", if_instruction_o, 32'hDA5A_0E8F);

        cycle();
        lat = 3;
        @(negedge clk);
        cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("t7_rst_req", 32'(imem_bus.imem_request), 32'd0);
        cycle();
        rst = 1'b0;
        lat = 0;
        model_stream(32'hBFC0_0000, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t7_restart_pc", if_exception_pc_o, 32'hBFC0_0000);
        chk("t7_restart_stall", 32'(if_stall_o), 32'd0);
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
